alarm_timer: RTL and testbench
==============================

// Module: alarm_timer
// PURPOSE
//   Memory-mapped countdown alarm. Loaded value counts down at clk/divideBy and raises a level
//   interrupt at zero, pushing an event to the CPU instead of being polled. Sits on the
//   peripheral bus beside the free-running timer, same chipSelect/write/writeCommand protocol.
// PARAMETERS
//   DEFAULT_DIV   64   prescaler divisor after reset (9-bit)
//   WIDTH         32   countdown/reload register width
// PORTS
//   clk           in   1      system clock
//   rst           in   1      reset, asynchronous, active-low
//   chipSelect    in   1      qualifies write/writeCommand; both ignored when low
//   write         in   1      load reload AND count with dataIn
//   writeCommand  in   1      command: dataIn[2:0]=cmd, dataIn[31:3]=arg
//   dataIn        in   32     bus write data
//   dataOut       out  32     current count (combinational from register)
//   irq           out  1      alarm interrupt, level, sticky until ack
// BEHAVIOUR
//   Reset (rst low, async): count=0, reload=0, divideBy=DEFAULT_DIV, divider=0,
//     periodic=0, state=IDLE, irq=0, dataOut=0.
//   States: IDLE (stopped), RUN (counting), EXPIRED (one-shot reached zero).
//   Prescaler: in RUN, divider increments each clk; at divider==divideBy-1 -> divider=0, tick=1.
//     divideBy==0 behaves as 1 (tick every cycle). divider held at 0 outside RUN.
//   Tick in RUN: count>1 -> count-1. count==1 -> count=0, irq=1 on that edge;
//     one-shot -> EXPIRED; periodic -> count=reload, stay RUN (reload==0 -> EXPIRED).
//   Commands (chipSelect & writeCommand):
//     0 STOP   : state=IDLE, divider=0; count, irq untouched
//     1 SETDIV : divideBy=arg[8:0]; divider not cleared
//     2 START  : divider=0; count!=0 -> RUN; count==0 -> EXPIRED, irq=1 next edge
//     3 ACK    : irq=0; EXPIRED -> IDLE
//     4 MODE   : periodic=arg[0] (see CONFIGURATION)
//     5..7     : ignored
//   write (chipSelect & write): reload=count=dataIn, divider=0; state unchanged.
//   Priority same cycle: write > writeCommand (command dropped); write > tick decrement;
//     expiry > ACK (irq stays 1); STOP > tick (no decrement).
//   Writes during RUN restart the period from the new value; no wrap below zero.
//   Latency: command/write effect visible on dataOut/irq the cycle after the edge.
// CONFIGURATION
//   ALARM_TIMER_PERIODIC_EN defined: periodic flag and cmd 4 implemented as above.
//   Undefined: periodic hard-wired 0, cmd 4 ignored, one-shot only; reload kept only for writes.
// STRUCTURE
//   Package alarm_timer_pkg: cmd codes (CMD_STOP..CMD_MODE), state enum {IDLE,RUN,EXPIRED},
//     DEFAULT_DIV constant, field slices CMD_LSB/CMD_MSB/ARG_LSB.
//   Sub-module timer_prescaler: divideBy, enable, clear -> 1-cycle tick pulse.
// TESTING
//   1 Reset: rst low mid-RUN with irq=1 -> dataOut=0, irq=0, state IDLE immediately (async).
//   2 One-shot: SETDIV 1 (tick every clk), write 5, START -> dataOut 4,3,2,1,0; irq=1 the
//     5th cycle after START; stays 1 until ACK; ACK -> irq=0, IDLE.
//   3 Prescale: SETDIV 4, write 2, START -> count 1 after 4 clk, 0 and irq after 8 clk.
//   4 Periodic (ALARM_TIMER_PERIODIC_EN): MODE 1, SETDIV 1, write 3, START -> irq every
//     3 clk, dataOut 2,1,3,2,1,3; without macro irq once, count stays 0.
//   5 Collisions: ACK on expiry edge -> irq stays 1; write 7 while tick -> dataOut=7;
//     write+writeCommand(START) together -> count=dataIn, state unchanged.
//   6 Edge: START with count 0 -> irq=1 next cycle, EXPIRED; chipSelect=0 write -> no change.

Source files
------------

// File: rtl/alarm_timer_pkg.sv
// rtl/alarm_timer_pkg.sv - command codes, states and field positions for alarm_timer
package alarm_timer_pkg;

  localparam logic [8:0] DEFAULT_DIV = 9'd64;

  localparam int CMD_LSB = 0;
  localparam int CMD_MSB = 2;
  localparam int ARG_LSB = 3;

  localparam logic [2:0] CMD_STOP   = 3'd0;
  localparam logic [2:0] CMD_SETDIV = 3'd1;
  localparam logic [2:0] CMD_START  = 3'd2;
  localparam logic [2:0] CMD_ACK    = 3'd3;
  localparam logic [2:0] CMD_MODE   = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

endpackage

// File: rtl/alarm_timer_prescaler.sv
// rtl/alarm_timer_prescaler.sv - timer_prescaler: clk/divide_by tick pulse while enabled
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] divide_by,
  input  logic       enable,
  input  logic       clear,
  output logic       tick
);

  logic [8:0] divider;
  logic [8:0] last;

  // a divisor of 0 is treated as 1
  assign last = (divide_by == 9'd0) ? 9'd0 : divide_by - 9'd1;
  assign tick = enable && (divider == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divider <= 9'd0;
    end else if (clear || !enable || tick) begin
      divider <= 9'd0;
    end else begin
      divider <= divider + 9'd1;
    end
  end

endmodule

// File: rtl/alarm_timer.sv
// rtl/alarm_timer.sv - memory-mapped countdown alarm with sticky level irq
// Optional periodic reload mode: define ALARM_TIMER_PERIODIC_EN.
module alarm_timer
  import alarm_timer_pkg::*;
#(
  parameter logic [8:0] DEFAULT_DIV = alarm_timer_pkg::DEFAULT_DIV,
  parameter int         WIDTH       = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chipSelect,
  input  logic        write,
  input  logic        writeCommand,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        irq
);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic [8:0]       divide_by;
  logic             periodic;
  logic             tick;
  logic             wr_en;
  logic             cmd_en;
  logic [2:0]       cmd;
  logic             presc_clear;

  assign wr_en  = chipSelect && write;
  assign cmd_en = chipSelect && writeCommand && !write;
  assign cmd    = dataIn[CMD_MSB:CMD_LSB];

  assign presc_clear = wr_en || (cmd_en && (cmd == CMD_STOP || cmd == CMD_START));

  timer_prescaler u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .divide_by (divide_by),
    .enable    (state == RUN),
    .clear     (presc_clear),
    .tick      (tick)
  );

`ifdef ALARM_TIMER_PERIODIC_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      periodic <= 1'b0;
    end else if (cmd_en && cmd == CMD_MODE) begin
      periodic <= dataIn[ARG_LSB];
    end
  end
`else
  assign periodic = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      reload    <= '0;
      divide_by <= DEFAULT_DIV;
      irq       <= 1'b0;
    end else if (wr_en) begin
      count  <= WIDTH'(dataIn);
      reload <= WIDTH'(dataIn);
    end else begin
      if (cmd_en && cmd == CMD_SETDIV)
        divide_by <= dataIn[ARG_LSB+8:ARG_LSB];
      if (cmd_en && cmd == CMD_ACK) begin
        irq <= 1'b0;
        if (state == EXPIRED)
          state <= IDLE;
      end
      if (cmd_en && cmd == CMD_STOP) begin
        state <= IDLE;
      end else if (cmd_en && cmd == CMD_START) begin
        if (count != '0) begin
          state <= RUN;
        end else begin
          state <= EXPIRED;
          irq   <= 1'b1;
        end
      end else if (tick) begin
        if (count > WIDTH'(1)) begin
          count <= count - WIDTH'(1);
        end else begin
          // expiry overrides a same-cycle ACK
          irq <= 1'b1;
          if (periodic && reload != '0) begin
            count <= reload;
          end else begin
            count <= '0;
            state <= EXPIRED;
          end
        end
      end
    end
  end

  assign dataOut = 32'(count);

endmodule

// File: tb/tb_alarm_timer.sv
// tb/tb_alarm_timer.sv - scoreboard bench for alarm_timer
module tb_alarm_timer;

  localparam logic [2:0] C_STOP   = 3'd0;
  localparam logic [2:0] C_SETDIV = 3'd1;
  localparam logic [2:0] C_START  = 3'd2;
  localparam logic [2:0] C_ACK    = 3'd3;
  localparam logic [2:0] C_MODE   = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        chipSelect = 1'b0;
  logic        write = 1'b0;
  logic        writeCommand = 1'b0;
  logic [31:0] dataIn = 32'd0;
  logic [31:0] dataOut;
  logic        irq;

  always #5 clk = ~clk;

  alarm_timer dut (
    .clk          (clk),
    .rst          (rst),
    .chipSelect   (chipSelect),
    .write        (write),
    .writeCommand (writeCommand),
    .dataIn       (dataIn),
    .dataOut      (dataOut),
    .irq          (irq)
  );

  typedef struct packed {
    logic [31:0] cnt;
    logic        irq;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_total = 0;
  int    n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cmdw(input logic [2:0] c, input logic [28:0] arg);
    return {arg, c};
  endfunction

  task automatic cyc(input string tag, input logic cs, input logic wr, input logic wc,
                     input logic [31:0] din, input logic [31:0] ecnt, input logic eirq);
    exp_t  e;
    string t;
    @(negedge clk);
    chipSelect   = cs;
    write        = wr;
    writeCommand = wc;
    dataIn       = din;
    e.cnt = ecnt;
    e.irq = eirq;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq({t, ".cnt"}, dataOut, e.cnt);
    check_eq({t, ".irq"}, {31'd0, irq}, {31'd0, e.irq});
  endtask

  task automatic idle(input string tag, input logic [31:0] ecnt, input logic eirq);
    cyc(tag, 1'b0, 1'b0, 1'b0, 32'd0, ecnt, eirq);
  endtask

  task automatic wcmd(input string tag, input logic [2:0] c, input logic [28:0] arg,
                      input logic [31:0] ecnt, input logic eirq);
    cyc(tag, 1'b1, 1'b0, 1'b1, cmdw(c, arg), ecnt, eirq);
  endtask

  task automatic wdata(input string tag, input logic [31:0] v,
                       input logic [31:0] ecnt, input logic eirq);
    cyc(tag, 1'b1, 1'b1, 1'b0, v, ecnt, eirq);
  endtask

  initial begin
    #12;
    check_eq("rst.cnt", dataOut, 32'd0);
    check_eq("rst.irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // one-shot at full speed
    wcmd("os.div", C_SETDIV, 29'd1, 32'd0, 1'b0);
    wdata("os.wr", 32'd5, 32'd5, 1'b0);
    wcmd("os.start", C_START, 29'd0, 32'd5, 1'b0);
    for (int i = 0; i < 5; i++)
      idle("os.run", 32'(4 - i), i == 4);
    idle("os.hold", 32'd0, 1'b1);
    idle("os.hold", 32'd0, 1'b1);
    wcmd("os.ack", C_ACK, 29'd0, 32'd0, 1'b0);
    idle("os.idle", 32'd0, 1'b0);

    // prescaled by 4
    wcmd("ps.div", C_SETDIV, 29'd4, 32'd0, 1'b0);
    wdata("ps.wr", 32'd2, 32'd2, 1'b0);
    wcmd("ps.start", C_START, 29'd0, 32'd2, 1'b0);
    for (int i = 1; i <= 8; i++)
      idle("ps.run", (i < 4) ? 32'd2 : (i < 8) ? 32'd1 : 32'd0, i == 8);
    wcmd("ps.ack", C_ACK, 29'd0, 32'd0, 1'b0);

    // collisions
    wcmd("co.div", C_SETDIV, 29'd1, 32'd0, 1'b0);
    wdata("co.wr", 32'd2, 32'd2, 1'b0);
    wcmd("co.start", C_START, 29'd0, 32'd2, 1'b0);
    idle("co.run", 32'd1, 1'b0);
    wcmd("co.ack_exp", C_ACK, 29'd0, 32'd0, 1'b1);
    idle("co.hold", 32'd0, 1'b1);
    wcmd("co.ack", C_ACK, 29'd0, 32'd0, 1'b0);
    wdata("co.wr3", 32'd3, 32'd3, 1'b0);
    wcmd("co.start3", C_START, 29'd0, 32'd3, 1'b0);
    idle("co.run3", 32'd2, 1'b0);
    wdata("co.wr_tick", 32'd7, 32'd7, 1'b0);
    idle("co.run7", 32'd6, 1'b0);
    wcmd("co.stop_tick", C_STOP, 29'd0, 32'd6, 1'b0);
    idle("co.stopped", 32'd6, 1'b0);
    cyc("co.wr_cmd", 1'b1, 1'b1, 1'b1, cmdw(C_START, 29'd0), 32'd2, 1'b0);
    idle("co.wr_cmd_idle", 32'd2, 1'b0);
    idle("co.wr_cmd_idle", 32'd2, 1'b0);

    // edge cases
    wdata("ed.wr0", 32'd0, 32'd0, 1'b0);
    wcmd("ed.start0", C_START, 29'd0, 32'd0, 1'b1);
    idle("ed.exp", 32'd0, 1'b1);
    wcmd("ed.ack", C_ACK, 29'd0, 32'd0, 1'b0);
    cyc("ed.cs0_wr", 1'b0, 1'b1, 1'b0, 32'd9, 32'd0, 1'b0);
    cyc("ed.cs0_cmd", 1'b0, 1'b0, 1'b1, cmdw(C_START, 29'd0), 32'd0, 1'b0);
    idle("ed.quiet", 32'd0, 1'b0);

    // periodic mode
    wcmd("pe.mode", C_MODE, 29'd1, 32'd0, 1'b0);
    wdata("pe.wr", 32'd3, 32'd3, 1'b0);
    wcmd("pe.start", C_START, 29'd0, 32'd3, 1'b0);
`ifdef ALARM_TIMER_PERIODIC_EN
    idle("pe.run", 32'd2, 1'b0);
    idle("pe.run", 32'd1, 1'b0);
    idle("pe.run", 32'd3, 1'b1);
    idle("pe.run", 32'd2, 1'b1);
    idle("pe.run", 32'd1, 1'b1);
    idle("pe.run", 32'd3, 1'b1);
    wcmd("pe.ack", C_ACK, 29'd0, 32'd2, 1'b0);
    wcmd("pe.stop", C_STOP, 29'd0, 32'd2, 1'b0);
    wcmd("pe.mode0", C_MODE, 29'd0, 32'd2, 1'b0);
`else
    idle("pe.run", 32'd2, 1'b0);
    idle("pe.run", 32'd1, 1'b0);
    for (int i = 0; i < 4; i++)
      idle("pe.oneshot", 32'd0, 1'b1);
    wcmd("pe.ack", C_ACK, 29'd0, 32'd0, 1'b0);
`endif

    // async reset mid-RUN with irq set, then default divisor
    wdata("ar.wr0", 32'd0, 32'd0, 1'b0);
    wcmd("ar.start0", C_START, 29'd0, 32'd0, 1'b1);
    wdata("ar.wr5", 32'd5, 32'd5, 1'b1);
    wcmd("ar.start5", C_START, 29'd0, 32'd5, 1'b1);
    idle("ar.run", 32'd4, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("ar.async.cnt", dataOut, 32'd0);
    check_eq("ar.async.irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    wdata("ar.wr3", 32'd3, 32'd3, 1'b0);
    idle("ar.idle", 32'd3, 1'b0);
    wcmd("ar.start3", C_START, 29'd0, 32'd3, 1'b0);
    for (int i = 1; i <= 64; i++)
      idle("ar.div64", (i < 64) ? 32'd3 : 32'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
